sample_stream_player: RTL and testbench
=======================================

# sample_stream_player

Parametrised stimulus buffer that stores up to DEPTH binary sample words and then streams them, in load order, to a downstream datapath over a valid/ready handshake. It generalises file-driven single-word stimulus into a synthesizable, re-playable source: one-shot or looped playback, back-pressure, abort, and overflow reporting. It sits between the host/load path and the 32-bit modelling datapath input.

## Interface
- WIDTH, 32: sample word width in bits.
- DEPTH, 16: buffer capacity in words; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1: derived width of count; not overridden.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  empties the buffer and clears overflow (IDLE only).
- load_valid  in  1  load word present.
- load_data  in  WIDTH  word to store.
- load_ready  out  1  buffer accepts a word this cycle.
- start  in  1  begin playback (IDLE only).
- loop_en  in  1  sampled at start: 1 = loop forever, 0 = one pass.
- stop  in  1  abort playback.
- out_valid  out  1  out_data holds a valid sample.
- out_data  out  WIDTH  current sample.
- out_ready  in  1  downstream accepts sample.
- busy  out  1  high while in PLAY.
- done  out  1  one-cycle pulse after final transfer of a one-shot pass.
- count  out  CW  words stored (0..DEPTH).
- pass_cnt  out  16  completed passes in current playback; wraps at 2^16.
- overflow  out  1  sticky: load attempted while full.

## Operation
- Two states: IDLE, PLAY. Storage: DEPTH×WIDTH register array, write pointer = count, read pointer rd_ptr (CW-1 bits).
- IDLE: load_ready = !(count == DEPTH). load_valid & load_ready writes mem[count], count += 1. load_valid while full: no write, overflow ← 1.
- IDLE, clear = 1: count ← 0, overflow ← 0; clear beats start and load in the same cycle (load ignored, start ignored). Memory contents are not erased.
- IDLE, start = 1 with resulting count > 0 (including a word loaded the same cycle): → PLAY, rd_ptr ← 0, pass_cnt ← 0, loop mode latched from loop_en. start with count = 0 and no same-cycle load: ignored.
- PLAY: load_ready = 0, out_valid = 1, out_data = mem[rd_ptr]. start, clear, load_valid ignored (no overflow update).
- Transfer = out_valid & out_ready. On transfer with rd_ptr < count-1: rd_ptr += 1. On transfer with rd_ptr = count-1: pass_cnt += 1; if looping, rd_ptr ← 0 and stay in PLAY; else → IDLE and done pulses next cycle.
- stop in PLAY: → IDLE next cycle; a transfer in the same cycle completes (counts toward pass_cnt) but done is not pulsed. pass_cnt holds its value in IDLE until next start.
- out_data/out_valid stable while out_valid & !out_ready.
- count and memory persist across playbacks; replay without reload is legal.

## Timing
- Reset: state IDLE, count 0, rd_ptr 0, pass_cnt 0, overflow 0, done 0, out_valid 0, busy 0, load_ready 1; out_data don't-care but driven (mem[0]).
- Load: word written at the edge of the handshake cycle; count visible next cycle.
- start at edge N → out_valid = 1, out_data = mem[0] from cycle N+1.
- Throughput: one sample per cycle with out_ready held high; no bubble at loop wrap.
- One-shot: last transfer at edge M → out_valid = 0, busy = 0, done = 1 in cycle M+1; done = 0 in M+2.
- rst mid-PLAY: IDLE next cycle, count 0; no done pulse.
- out_valid does not depend combinationally on out_ready.

## Test plan
- Reset then load 0x00000001..0x00000004, start loop_en=0, out_ready=1 → four consecutive samples 1,2,3,4 from cycle after start, done pulses once, pass_cnt = 1, count stays 4.
- Same buffer, out_ready toggled 1,0,0,1,… → each sample held stable while stalled, exact order 1..4, no duplicates/drops.
- Loop mode, DEPTH=16 with 3 words (0xA,0xB,0xC), out_ready=1 for 9 cycles, then stop → A,B,C,A,B,C,A,B,C, pass_cnt = 3, no done, IDLE after stop.
- Fill 16 words, assert load_valid again → load_ready = 0, overflow = 1, count = 16; clear → count 0, overflow 0.
- Start with count = 0 → stays IDLE, out_valid 0; start + load_valid same cycle on empty buffer → PLAY with single sample, one-shot done after one transfer.
- Assert rst during PLAY at third sample → next cycle out_valid 0, count 0, pass_cnt 0, done 0.

Source files
------------

// File: rtl/sample_stream_player_if.sv
// -----------------------------------------------------------------------------
// sample_stream_player_if
// Handshake bundle for sample_stream_player: the load stream into the buffer
// and the playback stream out to the datapath.
//   load_valid / load_data / load_ready : host -> buffer word transfer
//   out_valid  / out_data  / out_ready  : buffer -> datapath sample transfer
// master: the host/datapath side (drives load_* and out_ready)
// slave : the player (drives load_ready and out_*)
// -----------------------------------------------------------------------------
interface sample_stream_player_if #(
    parameter int WIDTH = 32
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, out_data
    );

    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, out_data
    );
endinterface

// File: rtl/sample_stream_player.sv
// -----------------------------------------------------------------------------
// sample_stream_player
// Stores up to DEPTH sample words loaded by the host, then replays them in
// load order over a valid/ready stream, once or looped, with abort (stop)
// and a sticky overflow flag for loads attempted while full.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : load_valid/load_data/load_ready, out_valid/out_data/out_ready
//   clear              : empty buffer and clear overflow (IDLE only)
//   start, loop_en     : begin playback (IDLE only); loop_en latched at start
//   stop               : abort playback
//   busy               : high while playing
//   done               : one-cycle pulse after the last transfer of a one-shot pass
//   count              : words stored (0..DEPTH)
//   pass_cnt           : completed passes of the current/last playback
//   overflow           : sticky, load attempted while full
// -----------------------------------------------------------------------------
module sample_stream_player #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sample_stream_player_if.slave  bus,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   loop_en,
    input  logic                   stop,
    output logic                   busy,
    output logic                   done,
    output logic [CW-1:0]          count,
    output logic [15:0]            pass_cnt,
    output logic                   overflow
);
    localparam int            AW   = CW - 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_rd_ptr;
    logic [15:0]      r_pass_cnt;
    logic             r_overflow;
    logic             r_done;
    logic             r_loop;

    logic w_full;
    logic w_load_fire;
    logic w_xfer;
    logic w_last;

    assign w_full      = (r_count == FULL);
    // clear has priority over a same-cycle load
    assign w_load_fire = (r_state == S_IDLE) && !clear && bus.load_valid && !w_full;
    // out_valid is exactly "in PLAY", so a transfer is PLAY & out_ready
    assign w_xfer      = (r_state == S_PLAY) && bus.out_ready;
    assign w_last      = ({1'b0, r_rd_ptr} == (r_count - 1'b1));

    // Sample storage: written only in IDLE; contents survive clear and reset.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_count[AW-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_pass_cnt <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_loop     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        if (w_load_fire) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (bus.load_valid && w_full) begin
                            r_overflow <= 1'b1;
                        end
                        // a word loaded this same cycle makes an empty buffer playable
                        if (start && ((r_count != '0) || w_load_fire)) begin
                            r_state    <= S_PLAY;
                            r_rd_ptr   <= '0;
                            r_pass_cnt <= '0;
                            r_loop     <= loop_en;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                            r_rd_ptr   <= '0;
                            if (!r_loop) begin
                                r_state <= S_IDLE;
                                r_done  <= !stop;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                    if (stop) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.load_ready = (r_state == S_IDLE) && !w_full;
    assign bus.out_valid  = (r_state == S_PLAY);
    assign bus.out_data   = r_mem[r_rd_ptr];
    assign busy           = (r_state == S_PLAY);
    assign done           = r_done;
    assign count          = r_count;
    assign pass_cnt       = r_pass_cnt;
    assign overflow       = r_overflow;
endmodule

// File: tb/tb_sample_stream_player.sv
// -----------------------------------------------------------------------------
// tb_sample_stream_player
// Scoreboard bench: the stimulus side keeps the stored words in a queue and
// pushes the sample sequence each playback must produce; a negedge monitor
// pops and compares on every transfer and checks samples stay stable while
// stalled.
// -----------------------------------------------------------------------------
module tb_sample_stream_player;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          loop_en = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic [15:0]   pass_cnt;
    logic          overflow;

    always #5 clk = ~clk;

    sample_stream_player_if #(.WIDTH(WIDTH)) bus ();

    sample_stream_player #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clear    (clear),
        .start    (start),
        .loop_en  (loop_en),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .pass_cnt (pass_cnt),
        .overflow (overflow)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_buf[$];
    bit          m_ovf   = 1'b0;
    logic [31:0] exp_q[$];
    int          done_cnt = 0;
    bit          held = 1'b0;
    logic [31:0] held_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (held) chk("stall_stable", 64'(bus.out_data), 64'(held_val));
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sample", 64'(bus.out_data), 64'hDEAD_0000_0000_0000);
                    end else begin
                        chk("sample", 64'(bus.out_data), 64'(exp_q.pop_front()));
                    end
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_val = bus.out_data;
                end
            end else begin
                held = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_buf.delete();
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        #1;
        chk("load_ready", 64'(bus.load_ready), 64'(m_buf.size() < DEPTH));
        tick();
        bus.load_valid = 1'b0;
        if (m_buf.size() < DEPTH) m_buf.push_back(w);
        else m_ovf = 1'b1;
        chk("count", 64'(count), 64'(m_buf.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    // rdy_mode 0: always ready, 1: 1,0,0 repeating, 2: random.
    // One-shot runs (loop=0, do_stop=0) require n == buffer length.
    task automatic play(input bit loop, input int n, input int rdy_mode, input bit do_stop);
        int  len = m_buf.size();
        int  got = 0;
        int  cyc = 0;
        int  d0  = done_cnt;
        bit  rdy;
        for (int i = 0; i < n; i++) exp_q.push_back(m_buf[i % len]);
        start   = 1'b1;
        loop_en = loop;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("valid_after_start", 64'(bus.out_valid), 64'd1);
        while (got < n && cyc < 600) begin
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            @(negedge clk);
            if (bus.out_valid && rdy) got++;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("xfer_count", 64'(got), 64'(n));
        if (!loop && !do_stop) begin
            chk("oneshot_valid", 64'(bus.out_valid), 64'd0);
            chk("oneshot_busy", 64'(busy), 64'd0);
            chk("oneshot_done", 64'(done), 64'd1);
            chk("oneshot_pass", 64'(pass_cnt), 64'(n / len));
            tick();
            chk("done_drop", 64'(done), 64'd0);
            chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        end else begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk("stop_valid", 64'(bus.out_valid), 64'd0);
            chk("stop_busy", 64'(busy), 64'd0);
            chk("stop_pass", 64'(pass_cnt), 64'(n / len));
            tick();
            chk("stop_no_done", 64'(done_cnt - d0), 64'd0);
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("count_kept", 64'(count), 64'(len));
    endtask

    initial begin
        logic [31:0] w;
        int          len;
        int          n;
        bit          lp;

        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.out_ready  = 1'b0;
        tick();
        do_reset();
        chk("rst_load_ready", 64'(bus.load_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pass", 64'(pass_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // one-shot 1..4, then replay the same buffer with back-pressure
        for (int i = 1; i <= 4; i++) load_word(32'(i));
        play(1'b0, 4, 0, 1'b0);
        play(1'b0, 4, 1, 1'b0);

        // loop A,B,C for three passes then stop
        do_reset();
        load_word(32'hA);
        load_word(32'hB);
        load_word(32'hC);
        play(1'b1, 9, 0, 1'b1);

        // fill, overflow, clear
        do_reset();
        for (int i = 0; i < DEPTH; i++) load_word($urandom);
        load_word($urandom);
        chk("full_load_ready", 64'(bus.load_ready), 64'd0);
        clear = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        clear = 1'b0;
        bus.load_valid = 1'b0;
        m_buf.delete();
        m_ovf = 1'b0;
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_overflow", 64'(overflow), 64'd0);

        // start on empty buffer is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", 64'(busy), 64'd0);
        chk("empty_start_valid", 64'(bus.out_valid), 64'd0);

        // start together with the first load plays that single word
        w = $urandom;
        m_buf.push_back(w);
        exp_q.push_back(w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        start   = 1'b1;
        loop_en = 1'b0;
        tick();
        bus.load_valid = 1'b0;
        start = 1'b0;
        chk("sameload_busy", 64'(busy), 64'd1);
        chk("sameload_count", 64'(count), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("sameload_done", 64'(done), 64'd1);
        chk("sameload_pass", 64'(pass_cnt), 64'd1);
        chk("sameload_valid", 64'(bus.out_valid), 64'd0);
        chk("sameload_q", 64'(exp_q.size()), 64'd0);

        // reset while the third sample is presented
        do_reset();
        for (int i = 0; i < 4; i++) load_word($urandom);
        exp_q.push_back(m_buf[0]);
        exp_q.push_back(m_buf[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_buf.delete();
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_pass", 64'(pass_cnt), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_q", 64'(exp_q.size()), 64'd0);

        // randomized buffers, modes and back-pressure
        for (int r = 0; r < 6; r++) begin
            do_reset();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load_word($urandom);
            lp = 1'($urandom_range(0, 1));
            n  = lp ? len * $urandom_range(1, 3) + $urandom_range(0, len - 1) : len;
            play(lp, n, 2, lp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
